// File: rtl/mips_state_dump_controller.sv
// Freezes the single-cycle MIPS core and streams all registers, then optionally
// every data-memory word, over a valid/ready port before releasing the core.
module mips_state_dump_controller #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dump_mem,
    output logic                  cpu_halt,
    output logic [REG_ADDR_W-1:0] reg_rd_addr,
    input  logic [DATA_W-1:0]     reg_rd_data,
    output logic [MEM_ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_kind,
    output logic [MEM_ADDR_W-1:0] out_addr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_REG   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [MEM_ADDR_W-1:0] REG_LAST = MEM_ADDR_W'((1 << REG_ADDR_W) - 1);
    localparam logic [MEM_ADDR_W-1:0] MEM_LAST = {MEM_ADDR_W{1'b1}};
    localparam logic [MEM_ADDR_W-1:0] IDX_ONE  = MEM_ADDR_W'(1);

    logic [2:0]            state;
    logic [MEM_ADDR_W-1:0] idx;
    logic                  mem_sel;
    logic                  ld;
    logic                  last;

    assign ld   = !out_valid || out_ready;
    assign last = (state == S_REG) ? (idx == REG_LAST) : (idx == MEM_LAST);
    assign busy = (state != S_IDLE);

    // The shared index only reaches the port of the phase being dumped.
    assign reg_rd_addr = (state == S_REG) ? idx[REG_ADDR_W-1:0] : '0;
    assign mem_rd_addr = (state == S_MEM) ? idx : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            mem_sel   <= 1'b0;
            cpu_halt  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_kind  <= 1'b0;
            out_addr  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_HALT;
                        cpu_halt <= 1'b1;
                        mem_sel  <= dump_mem;
                    end
                end
                S_HALT: begin
                    idx   <= '0;
                    state <= S_REG;
                end
                S_REG, S_MEM: begin
                    // A stalled word (valid without ready) keeps everything frozen.
                    if (ld) begin
                        out_valid <= 1'b1;
                        out_addr  <= idx;
                        if (state == S_REG) begin
                            out_data <= reg_rd_data;
                            out_kind <= 1'b0;
                        end else begin
                            out_data <= mem_rd_data;
                            out_kind <= 1'b1;
                        end
                        if (last) begin
                            idx   <= '0;
                            state <= (state == S_REG && mem_sel) ? S_MEM : S_DRAIN;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        cpu_halt  <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_state_dump_controller.sv
// Bench for mips_state_dump_controller: table of dump scenarios checked through a
// word scoreboard, plus hand-written reset and start-collision sequences.
module tb_mips_state_dump_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        dump_mem;
    logic        cpu_halt;
    logic [3:0]  reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic [7:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_kind;
    logic [7:0]  out_addr;
    logic        busy;
    logic        done;

    logic [15:0] regs [16];
    logic [15:0] mem  [256];
    int          pc;
    int          pc_snap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } word_t;

    typedef struct {
        bit dmem;
        int stall1;
        int stall2;
        int restart_w;
        bit core_on;
        int exp_done;
    } case_t;

    word_t sb [$];
    case_t cases [5];

    assign reg_rd_data = regs[reg_rd_addr];
    assign mem_rd_data = mem[mem_rd_addr];

    mips_state_dump_controller #(
        .DATA_W(16), .REG_ADDR_W(4), .MEM_ADDR_W(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .dump_mem(dump_mem),
        .cpu_halt(cpu_halt), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_kind(out_kind), .out_addr(out_addr), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in for the core: each unhalted cycle writes $t0 (r8) and memory[3].
    task automatic core_step();
        regs[8] = 16'h7000 + 16'(pc);
        mem[3]  = 16'h3000 + 16'(pc);
        pc      = pc + 1;
    endtask

    task automatic run_case(input case_t c);
        int    e, words, s1, s2, first_e, done_e, dones;
        bit    prev_stall, restarted, halt_before, halt_drop, fin;
        word_t held, w;
        logic [15:0] exp_t0, exp_m3;
        sb.delete();
        words = 0; s1 = 3; s2 = 3; first_e = -1; done_e = -1; dones = 0;
        prev_stall = 0; restarted = 0; halt_drop = 0; fin = 0;
        held = '{1'b0, 8'h0, 16'h0};
        start = 1'b1; dump_mem = c.dmem; out_ready = 1'b1;
        halt_before = cpu_halt;
        @(posedge clock);
        e = 0;
        if (c.core_on && !halt_before) core_step();
        #1;
        start = 1'b0; dump_mem = 1'b0;
        pc_snap = pc;
        exp_t0 = 16'h7000 + 16'(pc_snap - 1);
        exp_m3 = 16'h3000 + 16'(pc_snap - 1);
        chk("halt_busy_e0", 32'({busy, cpu_halt}), 32'h3);
        for (int i = 0; i < 16; i++) sb.push_back('{1'b0, 8'(i), regs[i]});
        if (c.dmem) for (int j = 0; j < 256; j++) sb.push_back('{1'b1, 8'(j), mem[j]});
        while (!fin && e < c.exp_done + 20) begin
            halt_before = cpu_halt;
            @(posedge clock);
            e++;
            if (c.core_on && !halt_before) core_step();
            #1;
            start = 1'b0;
            if (done) begin
                dones++;
                if (done_e < 0) begin
                    done_e = e;
                    chk("halt_release", 32'(cpu_halt), 32'h0);
                end
            end
            if (done_e < 0 && !cpu_halt) halt_drop = 1;
            if (c.core_on && done_e < 0) chk("pc_frozen", 32'(pc), 32'(pc_snap));
            if (done_e >= 0 && e == done_e + 1) begin
                chk("done_pulse_end", 32'(done), 32'h0);
                chk("busy_idle", 32'(busy), 32'h0);
                fin = 1;
            end
            if (out_valid) begin
                if (first_e < 0) first_e = e;
                if (prev_stall)
                    chk("stall_hold", 32'({held.kind, held.addr, held.data}),
                        32'({out_kind, out_addr, out_data}));
                if (words == c.stall1 && s1 > 0) begin
                    out_ready = 1'b0; s1--;
                end else if (words == c.stall2 && s2 > 0) begin
                    out_ready = 1'b0; s2--;
                end else begin
                    out_ready = 1'b1;
                end
                if (words == c.restart_w && !restarted) begin
                    start = 1'b1; dump_mem = ~c.dmem; restarted = 1;
                end
                if (out_ready) begin
                    prev_stall = 0;
                    words++;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'h1, 32'h0);
                    end else begin
                        w = sb.pop_front();
                        chk("word", 32'({out_kind, out_addr, out_data}), 32'({w.kind, w.addr, w.data}));
                        if (c.core_on && !out_kind && out_addr == 8'd8) chk("t0_prehalt", 32'(out_data), 32'(exp_t0));
                        if (c.core_on && out_kind && out_addr == 8'd3) chk("mem3_prehalt", 32'(out_data), 32'(exp_m3));
                        if (!c.core_on && !out_kind) chk("reg_value", 32'(out_data), 32'(16'h1000 + 16'(out_addr)));
                        if (out_kind && out_addr == 8'd255) chk("last_mem", 32'(out_data), 32'hA55A);
                    end
                end else begin
                    prev_stall = 1;
                    held = '{out_kind, out_addr, out_data};
                end
            end else begin
                out_ready = 1'b1;
            end
        end
        chk("finished", 32'(fin), 32'h1);
        chk("first_word_edge", 32'(first_e), 32'h2);
        chk("done_edge", 32'(done_e), 32'(c.exp_done));
        chk("done_count", 32'(dones), 32'h1);
        chk("halt_early_drop", 32'(halt_drop), 32'h0);
        chk("words_left", 32'(sb.size()), 32'h0);
        chk("words_seen", 32'(words), c.dmem ? 32'd272 : 32'd16);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)  regs[i] = 16'h1000 + 16'(i);
        for (int j = 0; j < 256; j++) mem[j]  = 16'(j) ^ 16'hA5A5;
        pc = 100;
        cases[0] = '{1'b0, -1, -1, -1, 1'b0, 18};
        cases[1] = '{1'b1, -1, -1, -1, 1'b0, 274};
        cases[2] = '{1'b1, 5, 271, -1, 1'b0, 280};
        cases[3] = '{1'b0, -1, -1, 10, 1'b0, 18};
        cases[4] = '{1'b1, -1, -1, -1, 1'b1, 274};

        reset = 1'b1; start = 1'b0; dump_mem = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_halt", 32'(cpu_halt), 32'h0);
        chk("rst_busy_done", 32'({busy, done}), 32'h0);
        chk("rst_out", 32'({out_valid, out_kind, out_addr, out_data}), 32'h0);
        chk("rst_addrs", 32'({reg_rd_addr, mem_rd_addr}), 32'h0);

        // Reset wins over a simultaneous start.
        start = 1'b1; dump_mem = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_start_busy", 32'({busy, cpu_halt}), 32'h0);
        reset = 1'b0; start = 1'b0; dump_mem = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_start_idle", 32'(busy), 32'h0);

        for (int k = 0; k < 4; k++) run_case(cases[k]);

        // Reset during the memory phase at address 40.
        start = 1'b1; dump_mem = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; dump_mem = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int n = 0; n < 100 && !hit; n++) begin
                @(posedge clock);
                #1;
                if (out_valid && out_kind && out_addr == 8'd40) hit = 1;
            end
            chk("reach_mem40", 32'(hit), 32'h1);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_halt_busy", 32'({cpu_halt, busy}), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_data", 32'({out_kind, out_addr, out_data}), 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_done", 32'({done, busy}), 32'h0);

        run_case(cases[0]);

        // Let the stand-in core run before freezing it.
        repeat (5) begin
            @(posedge clock);
            core_step();
        end
        #1;
        run_case(cases[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_state_dump_controller.md
# mips_state_dump_controller

Sequencer that freezes the single-cycle MIPS core and streams its architectural state, all 16 registers and then, optionally, every data-memory word, out over a valid/ready port. It then releases the core. It sits beside `single_cycle_mips` and borrows a spare combinational read port on the register file and one on the data memory. It drives the core's halt (PC/write-enable gate) input. Benches and the debug link use it to capture state mid-run instead of relying on simulator memory dumps.

## Interface
Parameters:
- `DATA_W`, 16, width of registers and data-memory words
- `REG_ADDR_W`, 4, register index width; register count = 2^REG_ADDR_W
- `MEM_ADDR_W`, 8, data-memory word index width; word count = 2^MEM_ADDR_W; must be ≥ REG_ADDR_W

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  dump request, sampled only in IDLE
- `dump_mem`  in  1  sampled with `start`: 1 = dump registers then memory, 0 = registers only
- `cpu_halt`  out  1  freezes PC update, register write and memory write in the core
- `reg_rd_addr`  out  REG_ADDR_W  register-file debug read address
- `reg_rd_data`  in  DATA_W  combinational read data for `reg_rd_addr`
- `mem_rd_addr`  out  MEM_ADDR_W  data-memory debug read address
- `mem_rd_data`  in  DATA_W  combinational read data for `mem_rd_addr`
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  sink accepts the word when high with `out_valid`
- `out_data`  out  DATA_W  dumped word
- `out_kind`  out  1  0 = register, 1 = memory
- `out_addr`  out  MEM_ADDR_W  register or memory index of `out_data`, zero-extended
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when the dump completes

## Operation
- States: IDLE, HALT, REG, MEM, DRAIN.
- IDLE: `start` = 1 → HALT. Set `cpu_halt` = 1 and latch `dump_mem`.
- HALT: one settling cycle so that the core's last instruction retires. Index is cleared to 0. Next state is REG.
- Load condition `ld` = !out_valid || out_ready, evaluated in REG and MEM only.
- REG: `reg_rd_addr` = index. On `ld`:
  - capture `out_data` ← `reg_rd_data`, `out_kind` ← 0, `out_addr` ← index; set `out_valid` = 1.
  - If index = 2^REG_ADDR_W−1, clear the index and go to MEM (latched dump_mem = 1) or DRAIN (dump_mem = 0).
  - Otherwise, increment the index.
- MEM: same rules as REG, using `mem_rd_addr` / `mem_rd_data` with `out_kind` = 1. After index = 2^MEM_ADDR_W−1, go to DRAIN.
- DRAIN: hold the last word. When `out_valid && out_ready`:
  - clear `out_valid` and `cpu_halt`;
  - pulse `done` = 1 for one cycle;
  - return to IDLE.
- In any non-load cycle: an accepted word (`out_valid && out_ready`) clears `out_valid`. A stalled word (`out_ready` = 0) holds `out_data`, `out_kind` and `out_addr` stable.
- `start` is ignored while `busy`. `dump_mem` is ignored outside an accepted `start`.
- `reg_rd_addr` and `mem_rd_addr` are driven from the shared index register. The address for the inactive port holds 0.
- Index arithmetic is unsigned, MEM_ADDR_W bits wide. There is no wrap-around beyond the terminal index; the terminal compare selects the state change.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: `cpu_halt` 0, `busy` 0, `done` 0, `out_valid` 0, `out_data` 0, `out_kind` 0, `out_addr` 0, `reg_rd_addr` 0, `mem_rd_addr` 0. State is IDLE.
- `reset` is asserted mid-dump: all outputs return to their reset values after that edge. `cpu_halt` drops immediately and no `done` pulse is produced. A partial stream is discarded by the sink.
- `reset` and `start` high in the same cycle: reset wins.
- `start` sampled at edge 0: `cpu_halt` = `busy` = 1 after edge 0; REG is entered after edge 1; the first word is valid after edge 2.
- With `out_ready` held at 1, one word is produced per cycle.
  - Word n is valid after edge 2+n.
  - The last word is valid after edge 1+N, where N = 16 (registers only) or 16+2^MEM_ADDR_W.
  - `done` = 1 and `cpu_halt` = 0 after edge 2+N; `done` = 0 after edge 3+N.
- Each cycle with `out_ready` = 0 while `out_valid` = 1 delays all subsequent words by one cycle.

## Test plan
- Registers only: preload register i = 0x1000+i. Pulse `start` with `dump_mem` = 0 and hold `out_ready` = 1. Required: 16 words 0x1000..0x100F with `out_kind` 0 and `out_addr` 0..15 on consecutive cycles. `done` pulses after edge 18; `cpu_halt` is high for edges 0..17 only.
- Full dump: preload memory word j = j XOR 0xA5A5 and use `dump_mem` = 1. Required: 16 register words, then 256 memory words with `out_kind` 1 and `out_addr` 0..255. The last word is 0xA55A at address 255. `done` pulses after edge 274.
- Backpressure: drop `out_ready` for 3 cycles on word 5 and on the final memory word. Required: those words are held unchanged, nothing is lost or duplicated, and `done` is delayed by 6 cycles.
- Ignored start: pulse `start` again at the 10th word. Required: the sequence is unaffected and exactly one `done` pulse occurs.
- Reset mid-dump: assert `reset` during the MEM phase at address 40. Required: after the next edge, `out_valid` = 0, `cpu_halt` = 0, `busy` = 0 and there is no `done` pulse. A fresh `start` then dumps from register 0.
- Core freeze: run a program whose next instruction writes `$t0` and memory[3], and pulse `start`. Required: the dumped `$t0` and memory[3] match pre-halt values, and the PC is unchanged from edge 1 until `done`.
